// File: rtl/action_input_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : action_input_arbiter_pkg                                        |
// | Purpose  : Shared types for the per-action input arbiter: source-select    |
// |            mode encoding, per-channel state encoding and a small helper    |
// |            used to size the channel counters.                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package action_input_arbiter_pkg;

  // Source select for every action channel.
  typedef enum logic [1:0] {
    MODE_BUTTON = 2'd0,
    MODE_SENSOR = 2'd1,
    MODE_EITHER = 2'd2,
    MODE_OFF    = 2'd3
  } input_mode_t;

  // Per-channel life cycle.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } action_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/action_input_arbiter_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : action_input_arbiter_channel                                    |
// | Purpose  : One action channel: 2-flop synchronisers on both raw sources,   |
// |            source select, and the IDLE/ARMING/ACTIVE/COOLDOWN FSM with     |
// |            debounce, minimum hold and cooldown timing.                     |
// | Ports    : clk, reset_n     clock / async active-low reset                 |
// |            mode             registered source select (input_mode_t)        |
// |            sensor_raw       unsynchronised sensor request                  |
// |            button_raw       unsynchronised button request                  |
// |            flush            force IDLE at the next edge                    |
// |            grant            permission to enter ACTIVE this cycle          |
// |            level            channel ACTIVE                                 |
// |            pulse            one-cycle strobe after entering ACTIVE         |
// |            busy             channel not IDLE                               |
// |            qualify          debounce complete, would enter if granted      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module action_input_arbiter_channel
  import action_input_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic       sensor_raw,
  input  logic       button_raw,
  input  logic       flush,
  input  logic       grant,
  output logic       level,
  output logic       pulse,
  output logic       busy,
  output logic       qualify
);

  localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cool_last =
    CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam bit c_has_cool = (COOLDOWN_CYCLES > 0);

  logic [1:0]       sen_sync_q, sen_sync_d;
  logic [1:0]       btn_sync_q, btn_sync_d;
  action_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             sen_s, btn_s, r;

  assign sen_s = sen_sync_q[1];
  assign btn_s = btn_sync_q[1];

  always_comb begin
    r = 1'b0;
    case (mode)
      MODE_BUTTON: r = btn_s;
      MODE_SENSOR: r = sen_s;
      MODE_EITHER: r = btn_s | sen_s;
      default:     r = 1'b0;
    endcase
  end

  // Debounce finished with the input still present; the parent decides
  // whether this turns into an activation.
  assign qualify = (state_q == ST_ARMING) && r && (cnt_q == c_deb_last);

  always_comb begin
    sen_sync_d = {sen_sync_q[0], sensor_raw};
    btn_sync_d = {btn_sync_q[0], button_raw};
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (r) begin
            state_d = ST_ARMING;
            cnt_d   = '0;
          end
        end
        ST_ARMING: begin
          if (!r) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == c_deb_last) begin
            // Without the grant the count is held, so activation follows
            // on the first granted cycle.
            if (grant) begin
              state_d = ST_ACTIVE;
              cnt_d   = '0;
              pulse_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (cnt_q == c_hold_last) begin
            if (!r) begin
              state_d = c_has_cool ? ST_COOLDOWN : ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == c_cool_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_sync_q <= '0;
      btn_sync_q <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sen_sync_q <= sen_sync_d;
      btn_sync_q <= btn_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign level = (state_q == ST_ACTIVE);
  assign busy  = (state_q != ST_IDLE);
  assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/action_input_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : action_input_arbiter                                            |
// | Purpose  : Registered per-action source select (sensor / button) feeding   |
// |            runner: NUM_ACTIONS debounced channels, optional mutual         |
// |            exclusion by index priority, flush on mode change.             |
// | Ports    : clk, reset_n     clk_33m clock / async active-low reset         |
// |            mode             input_mode_t source select                     |
// |            sensor_act       raw sensor requests, active high               |
// |            button_act       raw button requests, active high               |
// |            act_level        registered action level                        |
// |            act_pulse        one-cycle strobe per activation                |
// |            busy             channel not IDLE                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module action_input_arbiter
  import action_input_arbiter_pkg::*;
#(
  parameter int NUM_ACTIONS     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int EXCLUSIVE       = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             mode,
  input  logic [NUM_ACTIONS-1:0] sensor_act,
  input  logic [NUM_ACTIONS-1:0] button_act,
  output logic [NUM_ACTIONS-1:0] act_level,
  output logic [NUM_ACTIONS-1:0] act_pulse,
  output logic [NUM_ACTIONS-1:0] busy
);

  localparam int CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, COOLDOWN_CYCLES) + 1);

  logic [1:0]             mode_q, mode_d;
  logic [1:0]             mode_prev_q, mode_prev_d;
  logic                   flush;
  logic [NUM_ACTIONS-1:0] qualify;
  logic [NUM_ACTIONS-1:0] grant;

  always_comb begin
    mode_d      = mode;
    mode_prev_d = mode_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= MODE_BUTTON;
      mode_prev_q <= MODE_BUTTON;
    end else begin
      mode_q      <= mode_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  // One-cycle flush after every change of the registered mode.
  assign flush = (mode_q != mode_prev_q);

  // Grant is built from the pre-grant "qualify" flags. When no channel is
  // active, the lowest qualifying channel always wins, so "no lower channel
  // qualifies" is the same as "no lower channel is entering", and the chain
  // stays free of combinational feedback through the channels.
  generate
    if (EXCLUSIVE != 0) begin : g_excl
      for (genvar i = 0; i < NUM_ACTIONS; i++) begin : g_grant
        localparam logic [NUM_ACTIONS-1:0] c_below =
          NUM_ACTIONS'((64'd1 << i) - 64'd1);
        assign grant[i] = ~(|act_level) & ~(|(qualify & c_below));
      end
    end else begin : g_free
      assign grant = '1;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_ACTIONS; i++) begin : g_ch
      action_input_arbiter_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
        .CNT_W           (CNT_W)
      ) u_ch (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode_q),
        .sensor_raw (sensor_act[i]),
        .button_raw (button_act[i]),
        .flush      (flush),
        .grant      (grant[i]),
        .level      (act_level[i]),
        .pulse      (act_pulse[i]),
        .busy       (busy[i]),
        .qualify    (qualify[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/action_input_arbiter.md
Name: action_input_arbiter

Overview:
Parametrised, registered replacement for the per-action source select (sensor vs. button) that feeds runner.
- Handles NUM_ACTIONS channels and synchronises every raw input.
- Applies per-action debounce, minimum hold and cooldown.
- Optionally enforces mutual exclusion between actions by index priority.
- Sits in the clk_33m domain, between the sensor/button sources and runner.

Parameters:
NUM_ACTIONS, 2, number of action channels (index 0 = jump, 1 = duck); legal 1..8
DEBOUNCE_CYCLES, 4, cycles the selected input must stay high before activation; legal >=1
HOLD_CYCLES, 8, minimum cycles act_level stays high once active; legal >=1
COOLDOWN_CYCLES, 16, cycles after release during which the channel ignores input; 0 = none
EXCLUSIVE, 1, 1 = at most one channel active; lower index has priority
CNT_W, $clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES,COOLDOWN_CYCLES)+1), internal counter width (derived)

Ports:
clk  input  1  clk_33m domain clock
reset_n  input  1  asynchronous, active-low reset
mode  input  2  runner_pkg::input_mode_t: BUTTON=0, SENSOR=1, EITHER=2, OFF=3
sensor_act  input  NUM_ACTIONS  sensor-derived action requests, active high
button_act  input  NUM_ACTIONS  button action requests, active high (already polarity-corrected)
act_level  output  NUM_ACTIONS  registered action level to runner
act_pulse  output  NUM_ACTIONS  one-cycle strobe on each activation
busy  output  NUM_ACTIONS  channel not IDLE (for LEDs)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While reset_n=0, all flops clear: act_level=0, act_pulse=0, busy=0, every channel IDLE, counters 0.
- Synchronisers: sensor_act and button_act each pass through 2-flop synchronisers.
- Mode select: r[i] = BUTTON: btn_s[i]; SENSOR: sen_s[i]; EITHER: btn_s[i]|sen_s[i]; OFF: 0.
- Mode change: mode is registered. If the registered value differs from the previous value, every channel goes to IDLE at the next edge and all outputs are 0 the cycle after.
- Per-channel FSM (cnt is a per-channel counter):
  - IDLE: r -> ARMING, cnt=0.
  - ARMING: !r -> IDLE. If cnt==DEBOUNCE_CYCLES-1 and the grant is held -> ACTIVE, cnt=0, act_pulse=1 for one cycle. If cnt==DEBOUNCE_CYCLES-1 without the grant, stay and hold cnt. Otherwise cnt++.
  - ACTIVE: act_level=1. cnt saturates at HOLD_CYCLES-1. If cnt==HOLD_CYCLES-1 and !r -> COOLDOWN (or IDLE if COOLDOWN_CYCLES==0), cnt=0.
  - COOLDOWN: input ignored. If cnt==COOLDOWN_CYCLES-1 -> IDLE, else cnt++.
- Latency: input high sampled at edge 1 gives act_level=1 and act_pulse=1 after edge DEBOUNCE_CYCLES+3. The ACTIVE state is registered; outputs decode it with no extra delay.
- Minimum high time: act_level high for max(HOLD_CYCLES, duration of r high in ACTIVE) cycles.
- Exclusivity, EXCLUSIVE=1: grant[i] = no channel j<i is ACTIVE or entering ACTIVE this cycle, and no channel j>i is ACTIVE.
  - An active channel is never pre-empted.
  - On simultaneous qualification, the lowest index wins; the loser waits in ARMING.
- Exclusivity, EXCLUSIVE=0: grant is always 1.
- Glitch rejection: any drop of r during ARMING restarts debounce from IDLE.
- Reset mid-operation: immediate clear, no pulse emitted.
- Width rules: counters are CNT_W unsigned and never wrap.

Decomposition:
- runner_pkg additions: input_mode_t enum (BUTTON, SENSOR, EITHER, OFF) and action_state_t enum (IDLE, ARMING, ACTIVE, COOLDOWN).
- Sub-module action_channel: one FSM, synchroniser and counter per channel, with input grant and outputs level/pulse/busy/entering. Instantiated NUM_ACTIONS times via generate.
- Parent logic: mode register, mode-change flush and the grant priority chain.

Test Plan:
- Defaults, mode=BUTTON; button_act[0] high at edge 1, held 20 cycles -> act_pulse[0] high only after edge 7; act_level[0] high edges 7..23 (input low sampled by FSM at edge 23); then busy for 16 cooldown cycles.
- Short press: button_act[0] high 5 cycles -> act_level[0] high exactly 8 cycles (HOLD). A second press during cooldown is ignored: no pulse.
- Glitch: button_act[1] high 3 cycles, low 1, high 10 -> no activation until 4 consecutive synchronised highs; single act_pulse.
- Exclusive, mode=SENSOR: sensor_act=2'b11 on the same edge -> ch0 active at edge 7; ch1 held in ARMING and activates the edge after ch0 leaves ACTIVE. Both levels never high together.
- Mode flush: ch0 ACTIVE, mode BUTTON->OFF -> act_level=0 within 3 edges, busy=0. mode=EITHER with only sensor_act[0] high -> activates.
- Async reset: drop reset_n mid-ACTIVE, between edges -> outputs 0 immediately. After release, inputs low -> outputs stay 0.
